// File: rtl/trap_ctrl.sv
// trap_ctrl: trap/return sequencer between decode/execute and the CSR file.
// On ecall/ebreak/enabled irq it writes mepc, mcause and mstatus, then jumps
// to mtvec. On mret it restores mstatus and jumps to mepc. While idle, core
// CSR accesses pass straight through to the CSR file port.
module trap_ctrl #(
  parameter logic [11:0] ADDR_MSTATUS = 12'h000,
  parameter logic [11:0] ADDR_MEPC    = 12'h041,
  parameter logic [11:0] ADDR_MCAUSE  = 12'h042,
  parameter logic [11:0] ADDR_MTVEC   = 12'h005,
  parameter logic [31:0] CAUSE_EBREAK = 32'h0000_0003,
  parameter logic [31:0] CAUSE_ECALL  = 32'h0000_000B,
  parameter logic [31:0] CAUSE_IRQ    = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ecall,
  input  logic        ebreak,
  input  logic        mret,
  input  logic        irq,
  input  logic [31:0] pc_cur,
  input  logic        core_csr_w,
  input  logic [11:0] core_csr_addr,
  input  logic [31:0] core_csr_wdata,
  output logic        csr_w,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] pc_target
);

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_STAT,
    JUMP,
    R_STAT,
    R_JUMP
  } state_t;

  state_t      state;
  logic [31:0] mstatus_q;
  logic [31:0] epc_q;
  logic [31:0] cause_q;

  logic take_ebreak;
  logic take_ecall;
  logic take_mret;
  logic take_irq;
  logic accept;

  // Event qualification in priority order; only meaningful while idle.
  always_comb begin
    take_ebreak = (state == IDLE) && ebreak;
    take_ecall  = (state == IDLE) && !ebreak && ecall;
    take_mret   = (state == IDLE) && !ebreak && !ecall && mret;
    take_irq    = (state == IDLE) && !ebreak && !ecall && !mret && irq && mstatus_q[3];
    accept      = take_ebreak | take_ecall | take_mret | take_irq;
  end

  // CSR port mux, stall and redirect; reset silences everything but the pass-through.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    csr_w       = 1'b0;
    csr_addr    = core_csr_addr;
    csr_wdata   = core_csr_wdata;
    stall       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'h0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          csr_w = core_csr_w & ~accept;
          stall = accept;
        end
        W_EPC: begin
          csr_w     = 1'b1;
          csr_addr  = ADDR_MEPC;
          csr_wdata = epc_q;
          stall     = 1'b1;
        end
        W_CAUSE: begin
          csr_w     = 1'b1;
          csr_addr  = ADDR_MCAUSE;
          csr_wdata = cause_q;
          stall     = 1'b1;
        end
        W_STAT: begin
          csr_w     = 1'b1;
          csr_addr  = ADDR_MSTATUS;
          csr_wdata = {mstatus_q[31:8], mstatus_q[3], mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
          stall     = 1'b1;
        end
        JUMP: begin
          csr_addr    = ADDR_MTVEC;
          stall       = 1'b1;
          pc_redirect = 1'b1;
          pc_target   = {csr_rdata[31:2], 2'b00};
        end
        R_STAT: begin
          csr_w     = 1'b1;
          csr_addr  = ADDR_MSTATUS;
          csr_wdata = {mstatus_q[31:8], 1'b1, mstatus_q[6:4], mstatus_q[7], mstatus_q[2:0]};
          stall     = 1'b1;
        end
        R_JUMP: begin
          csr_addr    = ADDR_MEPC;
          stall       = 1'b1;
          pc_redirect = 1'b1;
          pc_target   = csr_rdata;
        end
        default: begin
          stall = 1'b1;
        end
      endcase
    end
  end

  // Sequencer state, captured trap context and the mstatus shadow.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      mstatus_q <= 32'h0;
      epc_q     <= 32'h0;
      cause_q   <= 32'h0;
    end else begin
      if (csr_w && (csr_addr == ADDR_MSTATUS)) begin
        mstatus_q <= csr_wdata;
      end
      unique case (state)
        IDLE: begin
          if (take_ebreak || take_ecall || take_irq) begin
            epc_q   <= pc_cur;
            cause_q <= take_ebreak ? CAUSE_EBREAK : (take_ecall ? CAUSE_ECALL : CAUSE_IRQ);
            state   <= W_EPC;
          end else if (take_mret) begin
            state <= R_STAT;
          end
        end
        W_EPC:   state <= W_CAUSE;
        W_CAUSE: state <= W_STAT;
        W_STAT:  state <= JUMP;
        R_STAT:  state <= R_JUMP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed bench for trap_ctrl. A behavioural model turns each
// accepted event into a list of expected CSR-port steps; a single compare
// process checks every cycle, and the stimulus pins key values with literals.
module tb_trap_ctrl;

  localparam logic [11:0] A_MSTATUS = 12'h000;
  localparam logic [11:0] A_MEPC    = 12'h041;
  localparam logic [11:0] A_MCAUSE  = 12'h042;
  localparam logic [11:0] A_MTVEC   = 12'h005;

  logic        clk;
  logic        rst;
  logic        ecall, ebreak, mret, irq;
  logic [31:0] pc_cur;
  logic        core_csr_w;
  logic [11:0] core_csr_addr;
  logic [31:0] core_csr_wdata;
  logic        csr_w;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] pc_target;

  int checks = 0;
  int errors = 0;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .ecall(ecall), .ebreak(ebreak), .mret(mret), .irq(irq),
    .pc_cur(pc_cur),
    .core_csr_w(core_csr_w), .core_csr_addr(core_csr_addr), .core_csr_wdata(core_csr_wdata),
    .csr_w(csr_w), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment CSR file driven by the DUT's port.
  logic [31:0] env_csr [0:4095];
  assign csr_rdata = env_csr[csr_addr];
  always @(posedge clk) if (csr_w) env_csr[csr_addr] <= csr_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        w;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        jump;
  } step_t;

  step_t       q[$];
  logic [31:0] m_csr [0:4095];
  logic [31:0] m_mstatus;
  step_t       s;
  logic        e_w, e_stall, e_red, chk_wdata, m_trap, m_ret;
  logic [11:0] e_addr;
  logic [31:0] e_wdata, e_tgt, m_cause, ms;

  always @(negedge clk) begin
    chk_wdata = 1'b1;
    e_red     = 1'b0;
    e_tgt     = 32'h0;
    if (rst) begin
      e_w     = 1'b0;
      e_addr  = core_csr_addr;
      e_wdata = core_csr_wdata;
      e_stall = 1'b0;
      q.delete();
      m_mstatus = 32'h0;
    end else if (q.size() > 0) begin
      s         = q.pop_front();
      e_stall   = 1'b1;
      e_w       = s.w;
      e_addr    = s.addr;
      e_wdata   = s.wdata;
      chk_wdata = s.w;
      if (s.jump) begin
        e_red = 1'b1;
        e_tgt = (s.addr == A_MTVEC) ? (m_csr[A_MTVEC] & 32'hFFFF_FFFC) : m_csr[A_MEPC];
      end
    end else begin
      m_trap  = 1'b0;
      m_ret   = 1'b0;
      m_cause = 32'h0;
      if (ebreak)                       begin m_trap = 1'b1; m_cause = 32'h0000_0003; end
      else if (ecall)                   begin m_trap = 1'b1; m_cause = 32'h0000_000B; end
      else if (mret)                    m_ret = 1'b1;
      else if (irq && m_mstatus[3])     begin m_trap = 1'b1; m_cause = 32'h8000_000B; end
      if (m_trap) begin
        ms    = m_mstatus;
        ms[7] = m_mstatus[3];
        ms[3] = 1'b0;
        q.push_back('{1'b1, A_MEPC, pc_cur, 1'b0});
        q.push_back('{1'b1, A_MCAUSE, m_cause, 1'b0});
        q.push_back('{1'b1, A_MSTATUS, ms, 1'b0});
        q.push_back('{1'b0, A_MTVEC, 32'h0, 1'b1});
      end
      if (m_ret) begin
        ms    = m_mstatus;
        ms[3] = m_mstatus[7];
        ms[7] = 1'b1;
        q.push_back('{1'b1, A_MSTATUS, ms, 1'b0});
        q.push_back('{1'b0, A_MEPC, 32'h0, 1'b1});
      end
      e_w     = core_csr_w & ~(m_trap | m_ret);
      e_addr  = core_csr_addr;
      e_wdata = core_csr_wdata;
      e_stall = m_trap | m_ret;
    end

    check("csr_w", {31'h0, csr_w}, {31'h0, e_w});
    check("csr_addr", {20'h0, csr_addr}, {20'h0, e_addr});
    if (chk_wdata) check("csr_wdata", csr_wdata, e_wdata);
    check("stall", {31'h0, stall}, {31'h0, e_stall});
    check("pc_redirect", {31'h0, pc_redirect}, {31'h0, e_red});
    check("pc_target", pc_target, e_tgt);

    if (e_w) begin
      m_csr[e_addr] = e_wdata;
      if (e_addr == A_MSTATUS) m_mstatus = e_wdata;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ecall = 0; ebreak = 0; mret = 0; irq = 0;
    core_csr_w = 0; core_csr_addr = 12'h000; core_csr_wdata = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      env_csr[i] = 32'h0;
      m_csr[i]   = 32'h0;
    end
    env_csr[A_MTVEC] = 32'h0000_0103;
    m_csr[A_MTVEC]   = 32'h0000_0103;
    m_mstatus        = 32'h0;

    // Reset with a core write and an ecall pending: only pass-through survives.
    quiet();
    rst = 1; pc_cur = 32'h0; ecall = 1;
    core_csr_w = 1; core_csr_addr = 12'h123; core_csr_wdata = 32'hCAFE_0001;
    @(negedge clk);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_csr_w", {31'h0, csr_w}, 32'h0);
    check("rst_redirect", {31'h0, pc_redirect}, 32'h0);
    check("rst_addr_pass", {20'h0, csr_addr}, 32'h123);
    tick();
    quiet(); rst = 0;
    @(negedge clk);
    check("idle_stall", {31'h0, stall}, 32'h0);
    tick();

    // ecall at 0x40, mtvec=0x103; a stray ebreak mid-sequence is ignored.
    ecall = 1; pc_cur = 32'h40;
    @(negedge clk); check("ecall_T_stall", {31'h0, stall}, 32'h1);
    tick(); ecall = 0; ebreak = 1;
    @(negedge clk);
    check("ecall_T1_w", {31'h0, csr_w}, 32'h1);
    check("ecall_T1_addr", {20'h0, csr_addr}, 32'h041);
    check("ecall_T1_wdata", csr_wdata, 32'h40);
    tick(); ebreak = 0;
    @(negedge clk);
    check("ecall_T2_addr", {20'h0, csr_addr}, 32'h042);
    check("ecall_T2_wdata", csr_wdata, 32'h0000_000B);
    tick();
    @(negedge clk);
    check("ecall_T3_addr", {20'h0, csr_addr}, 32'h000);
    check("ecall_T3_wdata", csr_wdata, 32'h0);
    tick();
    @(negedge clk);
    check("ecall_T4_redirect", {31'h0, pc_redirect}, 32'h1);
    check("ecall_T4_target", pc_target, 32'h0000_0100);
    check("ecall_T4_stall", {31'h0, stall}, 32'h1);
    tick();
    @(negedge clk); check("ecall_T5_stall", {31'h0, stall}, 32'h0);
    tick();

    // Enable MIE from the core, then take an interrupt at 0x80.
    core_csr_w = 1; core_csr_addr = A_MSTATUS; core_csr_wdata = 32'h0000_0008;
    @(negedge clk); check("core_mstatus_w", {31'h0, csr_w}, 32'h1);
    tick(); quiet(); irq = 1; pc_cur = 32'h80;
    @(negedge clk); check("irq_T_stall", {31'h0, stall}, 32'h1);
    tick();
    @(negedge clk); check("irq_T1_wdata", csr_wdata, 32'h80);
    tick();
    @(negedge clk); check("irq_T2_cause", csr_wdata, 32'h8000_000B);
    tick();
    @(negedge clk); check("irq_T3_mstatus", csr_wdata, 32'h0000_0080);
    tick();
    @(negedge clk); check("irq_T4_target", pc_target, 32'h0000_0100);
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("irq_not_retaken", {31'h0, stall}, 32'h0);
      tick();
    end
    irq = 0;

    // ebreak+ecall together with a core write: ebreak wins, write suppressed.
    ebreak = 1; ecall = 1; pc_cur = 32'h60;
    core_csr_w = 1; core_csr_addr = A_MEPC; core_csr_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("eb_T_core_w_suppressed", {31'h0, csr_w}, 32'h0);
    check("eb_T_stall", {31'h0, stall}, 32'h1);
    tick(); quiet();
    @(negedge clk); check("eb_T1_epc", csr_wdata, 32'h60);
    tick();
    @(negedge clk); check("eb_T2_cause", csr_wdata, 32'h0000_0003);
    tick();
    @(negedge clk); check("eb_T3_mstatus", csr_wdata, 32'h0);
    tick();
    @(negedge clk); check("eb_T4_redirect", {31'h0, pc_redirect}, 32'h1);
    tick();

    // Prepare mstatus=0x80, mepc=0x44; irq with MIE=0 is ignored.
    core_csr_w = 1; core_csr_addr = A_MSTATUS; core_csr_wdata = 32'h0000_0080;
    @(negedge clk); tick();
    irq = 1; core_csr_addr = A_MEPC; core_csr_wdata = 32'h0000_0044;
    @(negedge clk);
    check("irq_off_pass_w", {31'h0, csr_w}, 32'h1);
    check("irq_off_pass_addr", {20'h0, csr_addr}, 32'h041);
    check("irq_off_pass_wdata", csr_wdata, 32'h44);
    check("irq_off_stall", {31'h0, stall}, 32'h0);
    tick(); quiet();

    // mret: restore MIE from MPIE, jump to mepc.
    mret = 1;
    @(negedge clk); check("mret_T_stall", {31'h0, stall}, 32'h1);
    tick(); mret = 0;
    @(negedge clk);
    check("mret_T1_addr", {20'h0, csr_addr}, 32'h000);
    check("mret_T1_wdata", csr_wdata, 32'h0000_0088);
    tick();
    @(negedge clk);
    check("mret_T2_w", {31'h0, csr_w}, 32'h0);
    check("mret_T2_redirect", {31'h0, pc_redirect}, 32'h1);
    check("mret_T2_target", pc_target, 32'h0000_0044);
    tick();
    @(negedge clk); check("mret_T3_stall", {31'h0, stall}, 32'h0);
    tick();

    // Reset during W_CAUSE abandons the sequence.
    ecall = 1; pc_cur = 32'h200;
    @(negedge clk); tick(); ecall = 0;
    @(negedge clk); tick();
    rst = 1;
    @(negedge clk);
    check("midrst_csr_w", {31'h0, csr_w}, 32'h0);
    check("midrst_stall", {31'h0, stall}, 32'h0);
    tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_stall", {31'h0, stall}, 32'h0);
      check("postrst_csr_w", {31'h0, csr_w}, 32'h0);
      check("postrst_redirect", {31'h0, pc_redirect}, 32'h0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
